multi_tick_gen: RTL and testbench
=================================

// Module: multi_tick_gen
// PURPOSE
//  - Parametrised multi-channel clock divider / tick generator for the parking controller timing tree.
//  - Each channel outputs a square wave and a one-cycle tick (clk-domain enable) at a programmable rate.
//  - Rates are reprogrammable at run time (glitch-free) and all channels can be phase-aligned by a sync clear.
//  - Feeds display multiplex (500 Hz), blink (2 Hz) and seconds timekeeping (1 Hz) logic.
// PARAMETERS
//  - NCH           3                                        number of divider channels (1..8)
//  - CNT_W         26                                       half-period counter width
//  - DEFAULT_HALF  {26'd40_000,26'd20_000_000,26'd10_000_000}  packed NCH*CNT_W reset half-periods, ch0 in LSBs (ch0=2 Hz, ch1=1 Hz, ch2=500 Hz @40 MHz)
// PORTS
//  - clk           in   1                  system clock
//  - reset         in   1                  asynchronous, active-low reset
//  - ch_en         in   NCH                per-channel run enable (level)
//  - sync_clr      in   1                  1-cycle pulse: restart all channels in phase
//  - cfg_wr        in   1                  write strobe for half-period
//  - cfg_ch        in   3                  target channel index
//  - cfg_half      in   CNT_W              new half-period in clk cycles (>=1)
//  - cfg_err       out  1                  1-cycle pulse: rejected write
//  - clk_out       out  NCH                divided square waves
//  - tick          out  NCH                1-cycle pulse per clk_out rising edge
// BEHAVIOUR
//  - Reset: all cnt=0, clk_out=0, tick=0, cfg_err=0, pend=0, half[i]=DEFAULT_HALF[i], state=IDLE.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - Per-channel FSM IDLE/RUN. IDLE->RUN when ch_en[i]=1; RUN->IDLE same edge ch_en[i]=0 (cnt=0, clk_out=0, tick=0 next cycle).
//  - RUN: cnt counts 0..half-1; at cnt==half-1: cnt<=0, clk_out toggles; if toggling 0->1, tick=1 that same cycle.
//  - Period = 2*half clk cycles; first clk_out rise is half cycles after entering RUN; tick high exactly 1 cycle per period.
//  - half=1: clk_out toggles every cycle (divide-by-2); tick every 2nd cycle.
//  - cfg_wr with cfg_half==0 or cfg_ch>=NCH: ignored, cfg_err=1 next cycle.
//  - Valid cfg_wr: channel IDLE -> half updated next cycle; RUN -> stored in pend[i], applied at next terminal count (cnt==half-1), never mid-period.
//  - Two writes to one channel before wrap: last wins. Write on same cycle as terminal count: goes to pend, applied at following wrap.
//  - sync_clr: every channel cnt<=0, clk_out<=0, tick<=0, pending value applied; RUN channels stay RUN. cfg_wr coincident with sync_clr is applied immediately.
//  - ch_en falling coincident with cfg_wr: channel to IDLE and half loaded directly.
//  - Async reset mid-operation: outputs low immediately, programmed rates lost (back to DEFAULT_HALF).
// CONFIGURATION
//  - Macro MULTI_TICK_GEN_ONESHOT_EN:
//    - defined: adds ports oneshot in NCH and done out NCH.
//      - With oneshot[i]=1 at RUN entry, channel runs one full period (rise then fall), returns to IDLE, done[i]=1 for 1 cycle.
//      - ch_en[i] must drop before re-arm; held-high ch_en does not restart.
//    - undefined: ports absent, all channels free-running; no oneshot logic synthesised.
// STRUCTURE
//  - Package multi_tick_gen_pkg: CNT_W default, state encoding (IDLE=1'b0, RUN=1'b1), HZ_TO_HALF(clk_hz,f) constant function = clk_hz/(2*f).
//  - Sub-module tick_gen_channel (cnt, half, pend, FSM, clk_out/tick); top generates NCH instances plus cfg decode/error logic.
// TESTING
//  - Reset release, NCH=3, DEFAULT_HALF={3,2,1}, ch_en=3'b111 -> ch0 tick every 2 cycles, ch1 every 4, ch2 every 6; first clk_out rise 1/2/3 cycles after enable.
//  - ch0 RUN half=1; cfg_wr ch0 half=4 mid-period -> period 2 until next wrap, then clk_out high 4 / low 4 cycles, no runt pulse.
//  - cfg_wr cfg_ch=5 or cfg_half=0 -> cfg_err pulse 1 cycle, all half registers unchanged.
//  - Channels at random phase, sync_clr pulse -> all clk_out=0 next cycle, ticks re-aligned to identical cycle for equal half values.
//  - ch_en[1] dropped mid-high-phase -> clk_out[1]=0, tick[1]=0 next cycle; re-enable -> first rise after half cycles.
//  - ONESHOT_EN build, oneshot[0]=1, half=2 -> exactly one tick, clk_out high 2 cycles, done pulse, then IDLE while ch_en stays 1.

Source files
------------

// File: rtl/multi_tick_gen_pkg.sv
// multi_tick_gen_pkg: shared width default, channel state encoding and rate helper
package multi_tick_gen_pkg;

    localparam int CNT_W_DEF = 26;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned HZ_TO_HALF(input int unsigned clk_hz, input int unsigned f);
        return clk_hz / (2 * f);
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// tick_gen_channel: one divider channel with IDLE/RUN FSM and wrap-aligned rate reload
// Optional one-shot mode under MULTI_TICK_GEN_ONESHOT_EN
module tick_gen_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int               CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_HALF = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_sync_clr,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_half,
`ifdef MULTI_TICK_GEN_ONESHOT_EN
    input  logic             i_oneshot,
    output logic             o_done,
`endif
    output logic             o_clk_out,
    output logic             o_tick
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_v;
    logic             w_tc;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
    logic             r_os;
    logic             r_hold;
`endif

    assign w_tc = r_cnt == r_half - 1'b1;

    // Counter, FSM and outputs; a new rate only takes effect at a wrap, sync clear or stop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_half    <= RST_HALF;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            o_clk_out <= 1'b0;
            o_tick    <= 1'b0;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
            r_os      <= 1'b0;
            r_hold    <= 1'b0;
            o_done    <= 1'b0;
`endif
        end else begin
            o_tick <= 1'b0;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
            o_done <= 1'b0;
            if (!i_en) r_hold <= 1'b0;
`endif
            if (r_state == IDLE) begin
                r_cnt     <= '0;
                o_clk_out <= 1'b0;
                if (i_wr) r_half <= i_half;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
                if (i_en && !r_hold) begin
                    r_state <= RUN;
                    r_os    <= i_oneshot;
                end
`else
                if (i_en) r_state <= RUN;
`endif
            end else if (!i_en || i_sync_clr) begin
                r_state   <= i_en ? RUN : IDLE;
                r_cnt     <= '0;
                o_clk_out <= 1'b0;
                r_half    <= i_wr ? i_half : (r_pend_v ? r_pend : r_half);
                r_pend_v  <= 1'b0;
            end else begin
                r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
                if (w_tc) begin
                    o_clk_out <= ~o_clk_out;
                    o_tick    <= ~o_clk_out;
                    if (r_pend_v) r_half <= r_pend;
                end
                if (i_wr) begin
                    r_pend   <= i_half;
                    r_pend_v <= 1'b1;
                end else if (w_tc) begin
                    r_pend_v <= 1'b0;
                end
`ifdef MULTI_TICK_GEN_ONESHOT_EN
                if (w_tc && o_clk_out && r_os) begin
                    r_state <= IDLE;
                    o_done  <= 1'b1;
                    r_hold  <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NCH-channel square-wave / tick generator with run-time half-period programming
// Optional one-shot mode (oneshot/done ports) under MULTI_TICK_GEN_ONESHOT_EN
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter int                   NCH          = 3,
    parameter int                   CNT_W        = CNT_W_DEF,
    parameter logic [NCH*CNT_W-1:0] DEFAULT_HALF = {26'd40_000, 26'd20_000_000, 26'd10_000_000}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   ch_en,
    input  logic             sync_clr,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
`ifdef MULTI_TICK_GEN_ONESHOT_EN
    input  logic [NCH-1:0]   oneshot,
    output logic [NCH-1:0]   done,
`endif
    output logic             cfg_err,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic           w_bad;
    logic [NCH-1:0] w_wr;

    assign w_bad = cfg_wr && (cfg_half == '0 || 32'(cfg_ch) >= NCH);

    // Rejected writes report one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cfg_err <= 1'b0;
        else        cfg_err <= w_bad;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign w_wr[i] = cfg_wr && !w_bad && cfg_ch == 3'(i);
        tick_gen_channel #(
            .CNT_W   (CNT_W),
            .RST_HALF(DEFAULT_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_en      (ch_en[i]),
            .i_sync_clr(sync_clr),
            .i_wr      (w_wr[i]),
            .i_half    (cfg_half),
`ifdef MULTI_TICK_GEN_ONESHOT_EN
            .i_oneshot (oneshot[i]),
            .o_done    (done[i]),
`endif
            .o_clk_out (clk_out[i]),
            .o_tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb_multi_tick_gen: randomized self-checking bench against a segment-based rate model
module tb_multi_tick_gen;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int VW    = 3 * NCH + 1;
    localparam logic [NCH*CNT_W-1:0] DH = {8'd3, 8'd2, 8'd1};

    logic             clk      = 1'b0;
    logic             reset    = 1'b0;
    logic [NCH-1:0]   ch_en    = '0;
    logic             sync_clr = 1'b0;
    logic             cfg_wr   = 1'b0;
    logic [2:0]       cfg_ch   = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic [NCH-1:0]   oneshot  = '0;
    logic             cfg_err;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
    logic [NCH-1:0]   done;
`endif

    int checks = 0;
    int errors = 0;

    // Model: each channel runs in segments of constant half; level = start level xor parity of elapsed/half
    int             m_h[NCH];
    int             m_e[NCH];
    int             m_pend[NCH];
    logic [NCH-1:0] m_run, m_lvl0, m_pv, m_out, m_tick, m_os, m_hold, m_done;
    logic           m_err;

    multi_tick_gen #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_HALF(DH)) dut (
        .clk     (clk),
        .reset   (reset),
        .ch_en   (ch_en),
        .sync_clr(sync_clr),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_half(cfg_half),
`ifdef MULTI_TICK_GEN_ONESHOT_EN
        .oneshot (oneshot),
        .done    (done),
`endif
        .cfg_err (cfg_err),
        .clk_out (clk_out),
        .tick    (tick)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] obs();
`ifdef MULTI_TICK_GEN_ONESHOT_EN
        return {done, clk_out, tick, cfg_err};
`else
        return {{NCH{1'b0}}, clk_out, tick, cfg_err};
`endif
    endfunction

    function automatic logic [VW-1:0] expv();
        return {m_done, m_out, m_tick, m_err};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_h[c]    = int'(DH[c*CNT_W +: CNT_W]);
            m_e[c]    = 0;
            m_pend[c] = 0;
        end
        {m_run, m_lvl0, m_pv, m_out, m_tick, m_os, m_hold, m_done} = '0;
        m_err = 1'b0;
    endfunction

    function automatic void model_step();
        logic bad, wr, lvl;
        bad   = cfg_wr && (cfg_half == 0 || int'(cfg_ch) >= NCH);
        m_err = bad;
        for (int c = 0; c < NCH; c++) begin
            wr        = cfg_wr && !bad && int'(cfg_ch) == c;
            m_tick[c] = 1'b0;
            m_done[c] = 1'b0;
            if (!m_run[c]) begin
                m_out[c]  = 1'b0;
                m_e[c]    = 0;
                m_lvl0[c] = 1'b0;
                if (wr) m_h[c] = int'(cfg_half);
                if (ch_en[c] && !m_hold[c]) begin
                    m_run[c] = 1'b1;
                    m_os[c]  = oneshot[c];
                end
            end else if (!ch_en[c] || sync_clr) begin
                m_out[c]  = 1'b0;
                m_e[c]    = 0;
                m_lvl0[c] = 1'b0;
                m_h[c]    = wr ? int'(cfg_half) : (m_pv[c] ? m_pend[c] : m_h[c]);
                m_pv[c]   = 1'b0;
                m_run[c]  = ch_en[c];
            end else begin
                m_e[c]++;
                if (m_e[c] % m_h[c] == 0) begin
                    lvl       = m_lvl0[c] ^ ((m_e[c] / m_h[c]) % 2 == 1);
                    m_out[c]  = lvl;
                    m_tick[c] = lvl;
                    if (m_pv[c]) begin
                        m_lvl0[c] = lvl;
                        m_h[c]    = m_pend[c];
                        m_e[c]    = 0;
                        m_pv[c]   = 1'b0;
                    end
                    if (m_os[c] && !lvl) begin
                        m_run[c]  = 1'b0;
                        m_done[c] = 1'b1;
                        m_hold[c] = 1'b1;
                    end
                end else begin
                    m_out[c] = m_lvl0[c] ^ ((m_e[c] / m_h[c]) % 2 == 1);
                end
                if (wr) begin
                    m_pend[c] = int'(cfg_half);
                    m_pv[c]   = 1'b1;
                end
            end
            if (!ch_en[c]) m_hold[c] = 1'b0;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int first[NCH];
        int nt[NCH];
        int exp_nt[NCH] = '{6, 3, 2};
        reset = 1'b0;
        ch_en = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_hold got %b exp 0", obs());
        end
        reset = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            first[c] = -1;
            nt[c]    = 0;
        end
        for (int k = 0; k <= 12; k++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_run k=%0d got %b exp %b", k, obs(), expv());
            end
            for (int c = 0; c < NCH; c++) begin
                if (tick[c]) nt[c]++;
                if (clk_out[c] && first[c] < 0) first[c] = k;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (first[c] != c + 1) begin
                errors++;
                $display("FAIL first_rise ch%0d got %0d exp %0d", c, first[c], c + 1);
            end
            checks++;
            if (nt[c] != exp_nt[c]) begin
                errors++;
                $display("FAIL tick_count ch%0d got %0d exp %0d", c, nt[c], exp_nt[c]);
            end
        end
    endtask

    task automatic test_retune();
        int len = 0, got4 = 0, runt = 0;
        logic prev;
        cfg_wr   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_half = 8'd4;
        step();
        cfg_wr = 1'b0;
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL retune_wr got %b exp %b", obs(), expv());
        end
        prev = clk_out[0];
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL retune k=%0d got %b exp %b", k, obs(), expv());
            end
            if (clk_out[0]) len++;
            if (prev && !clk_out[0]) begin
                if (len == 4) got4++;
                if (len == 2 || len == 3) runt++;
                len = 0;
            end
            prev = clk_out[0];
        end
        checks++;
        if (got4 < 3 || runt != 0) begin
            errors++;
            $display("FAIL retune_shape high4=%0d runts=%0d exp high4>=3 runts=0", got4, runt);
        end
    endtask

    task automatic test_cfg_err();
        logic [2:0]       bad_ch[3]   = '{3'd5, 3'd1, 3'd3};
        logic [CNT_W-1:0] bad_half[3] = '{8'd7, 8'd0, 8'd2};
        for (int j = 0; j < 3; j++) begin
            cfg_wr   = 1'b1;
            cfg_ch   = bad_ch[j];
            cfg_half = bad_half[j];
            step();
            cfg_wr = 1'b0;
            checks++;
            if (obs() !== expv() || cfg_err !== 1'b1) begin
                errors++;
                $display("FAIL cfg_err_pulse j=%0d got %b exp %b", j, obs(), expv());
            end
        end
        step();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clear got %b exp 0", cfg_err);
        end
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL cfg_err_after k=%0d got %b exp %b", k, obs(), expv());
            end
        end
    endtask

    task automatic test_sync_clr();
        logic [CNT_W-1:0] h = CNT_W'($urandom_range(1, 6));
        logic [2:0]       chs[3] = '{3'd0, 3'd2, 3'd1};
        for (int j = 0; j < 3; j++) begin
            cfg_wr   = 1'b1;
            cfg_ch   = chs[j];
            cfg_half = (j == 2) ? CNT_W'($urandom_range(1, 6)) : h;
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL sync_prog j=%0d got %b exp %b", j, obs(), expv());
            end
        end
        cfg_wr = 1'b0;
        repeat ($urandom_range(5, 20)) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL sync_phase got %b exp %b", obs(), expv());
            end
        end
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        checks++;
        if (clk_out !== '0 || obs() !== expv()) begin
            errors++;
            $display("FAIL sync_clear clk_out=%b got %b exp %b", clk_out, obs(), expv());
        end
        for (int k = 0; k < 24; k++) begin
            step();
            checks++;
            if (tick[0] !== tick[2] || obs() !== expv()) begin
                errors++;
                $display("FAIL sync_align k=%0d ticks %b got %b exp %b", k, tick, obs(), expv());
            end
        end
    endtask

    task automatic test_ch_en_drop();
        int n = 0;
        while (clk_out[1] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (clk_out[1] !== 1'b1 || obs() !== expv()) begin
            errors++;
            $display("FAIL drop_wait clk_out1=%b got %b exp %b", clk_out[1], obs(), expv());
        end
        ch_en[1] = 1'b0;
        step();
        checks++;
        if ({clk_out[1], tick[1]} !== 2'b00 || obs() !== expv()) begin
            errors++;
            $display("FAIL drop_low got %b exp %b", obs(), expv());
        end
        step();
        ch_en[1] = 1'b1;
        step();
        n = 0;
        while (clk_out[1] !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n != m_h[1]) begin
            errors++;
            $display("FAIL reenable_rise got %0d cycles exp %0d", n, m_h[1]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) ch_en = NCH'($urandom);
            cfg_wr   = $urandom_range(0, 3) == 0;
            cfg_ch   = 3'($urandom_range(0, 4));
            cfg_half = CNT_W'($urandom_range(0, 6));
            sync_clr = $urandom_range(0, 31) == 0;
`ifdef MULTI_TICK_GEN_ONESHOT_EN
            if ($urandom_range(0, 15) == 0) oneshot = NCH'($urandom);
`endif
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random k=%0d got %b exp %b", k, obs(), expv());
            end
        end
        {cfg_wr, sync_clr} = 2'b00;
        oneshot = '0;
    endtask

    task automatic test_async_reset();
        int n = 0;
        ch_en    = '1;
        cfg_wr   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_half = 8'd5;
        step();
        cfg_wr = 1'b0;
        repeat (12) step();
        while (clk_out === '0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL pre_reset got %b exp %b", obs(), expv());
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", obs());
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL post_reset k=%0d got %b exp %b", k, obs(), expv());
            end
        end
    endtask

`ifdef MULTI_TICK_GEN_ONESHOT_EN
    task automatic test_oneshot();
        int nt = 0, nh = 0, nd = 0;
        ch_en   = '0;
        oneshot = '0;
        repeat (2) step();
        cfg_wr   = 1'b1;
        cfg_ch   = 3'd0;
        cfg_half = 8'd2;
        step();
        cfg_wr     = 1'b0;
        oneshot[0] = 1'b1;
        ch_en[0]   = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL oneshot k=%0d got %b exp %b", k, obs(), expv());
            end
            nt += int'(tick[0]);
            nh += int'(clk_out[0]);
            nd += int'(done[0]);
        end
        checks++;
        if (nt != 1 || nh != 2 || nd != 1 || clk_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_shape ticks=%0d high=%0d done=%0d exp 1 2 1", nt, nh, nd);
        end
        ch_en   = '0;
        oneshot = '0;
        step();
    endtask
`endif

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_retune();
        test_cfg_err();
        test_sync_clr();
        test_ch_en_drop();
        test_random();
        test_async_reset();
`ifdef MULTI_TICK_GEN_ONESHOT_EN
        test_oneshot();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
